led7_scan_ctrl: RTL and testbench
=================================

// Module: led7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
//  Shares one led7 BCD decoder across all digits. Inserts an anti-ghost blanking gap
//  before each digit slot. Updates displayed digits only at frame boundaries (tear-free).
//  Sits between the system's BCD value producers and the board display pins.
// PARAMETERS
//  NDIG   4      number of digits scanned (>=2)
//  DIV    50000  clock cycles per digit slot (>=2)
//  BLANK  500    cycles at start of each slot with all digits off (0 <= BLANK < DIV)
// PORTS
//  clk         in   1        system clock; all logic rising-edge
//  reset       in   1        synchronous, active-high reset
//  value       in   4*NDIG   BCD digits; digit k = value[4k+3:4k]; digit 0 = least significant
//  load        in   1        one-cycle strobe; captures value into shadow register
//  lz_en       in   1        1 = suppress leading zeros
//  pending     out  1        shadow holds a value not yet shown
//  frame_tick  out  1        one-cycle pulse when a new frame starts
//  an          out  NDIG     digit enables, active-low
//  seg         out  7        segments {a,b,c,d,e,f,g}, active-low
// BEHAVIOUR
//  Reset (sync): cnt=0, idx=0, disp=0, shadow=0, pending=0, frame_tick=0, an='1, seg=7'h7F.
//   Reset mid-frame or mid-slot aborts the scan. Any pending load is discarded.
//  Prescaler: cnt counts 0..DIV-1. At cnt==DIV-1: cnt->0 and idx->idx+1; idx wraps NDIG-1->0.
//  Frame boundary (FB) = cnt==DIV-1 && idx==NDIG-1.
//  load=1, no FB: shadow<=value, pending<=1.
//  FB, no load: if pending, disp<=shadow and pending<=0. frame_tick<=1 for one cycle.
//  load=1 and FB together: disp<=value directly, shadow<=value, pending<=0, frame_tick<=1.
//  Outputs are registered from current cnt/idx/disp (1-cycle latency); no combinational
//   path from inputs to pins.
//   cnt < BLANK: an='1, seg=7'h7F.
//   cnt >= BLANK: an[idx]=0 (all other bits 1). seg=led7(disp digit idx), unless the digit
//    is blanked, in which case seg=7'h7F and an[idx] still =0.
//  Digit blanked if:
//   (a) its code > 9. The controller forces 7'h7F itself; the decoder default (all lit)
//       is never driven to the pins.
//   (b) lz_en=1, the digit is 0, and every higher digit is 0. Digit 0 is never blanked.
//  lz_en is sampled every cycle (not latched per frame).
//  Exactly one an bit is low at any time, or none. Never two.
//  Width rules: cnt is $clog2(DIV) bits; idx is $clog2(NDIG) bits.
//   The wrap comparison is explicit (==NDIG-1), so non-power-of-2 NDIG is valid.
// STRUCTURE
//  led7_pkg:
//   SEG_BLANK = 7'h7F
//   typedef logic [3:0] bcd_t
//   function lz_mask(disp, lz_en) -> NDIG-bit blank mask (pure combinational)
//  One sub-module: led7 (existing BCD->segment decoder), instantiated once on the
//   muxed digit.
//  Remaining logic inline: prescaler, idx counter, shadow/disp regs, output regs.
// TESTING (NDIG=4, DIV=8, BLANK=2 unless stated)
//  1. Reset, then run. an cycles 1110,1101,1011,0111, each low for 6 of 8 cycles,
//     with 1111 for 2 cycles between slots. frame_tick pulses every 32 cycles.
//  2. load with value=16'h1234 mid-frame. pending=1 until FB. Then digits 4,3,2,1
//     appear on slots 0..3 (seg 7'b1001100 on slot 0). pending=0 after FB.
//  3. load asserted exactly on the FB cycle with 16'h0005. disp updates that FB and
//     pending stays 0. Then set lz_en=1: slots 3..1 show seg=7F with an bit low;
//     slot 0 shows 7'b0100100.
//  4. value=16'h00A0, lz_en=0. Digit 1 (code A) shows 7F, not 7'h00.
//     Other digits show 7'b0000001.
//  5. Assert reset during slot 2 with pending=1. Next cycle an='1, seg=7F, pending=0.
//     After release, scan restarts at slot 0 and disp=0.
//  6. NDIG=3, DIV=5, BLANK=0. idx wraps 2->0 and an never shows 1111.

Source files
------------

// File: rtl/led7_pkg.sv
// Shared types, constants and the leading-zero blanking helper for the 7-segment scan controller.
package led7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         MAX_DIG   = 16;

  typedef logic [3:0] bcd_t;

  // Bit k set when digit k is zero and every higher digit is zero; digit 0 is never blanked.
  // Callers zero-extend their digit vector, so unused upper digits read as zero.
  function automatic logic [MAX_DIG-1:0] lz_mask(input logic [4*MAX_DIG-1:0] disp,
                                                 input logic                 lz_en);
    logic [MAX_DIG-1:0] mask;
    logic               hi_zero;
    mask    = '0;
    hi_zero = 1'b1;
    for (int k = MAX_DIG - 1; k >= 0; k--) begin
      hi_zero = hi_zero && (disp[4*k +: 4] == 4'd0);
      mask[k] = lz_en && hi_zero && (k != 0);
    end
    return mask;
  endfunction

endpackage

// File: rtl/led7.sv
// BCD to active-low 7-segment decoder, segments ordered {a,b,c,d,e,f,g}.
module led7
  import led7_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_bcd)
      4'd0:    o_seg = 7'b0000001;
      4'd1:    o_seg = 7'b1001111;
      4'd2:    o_seg = 7'b0010010;
      4'd3:    o_seg = 7'b0000110;
      4'd4:    o_seg = 7'b1001100;
      4'd5:    o_seg = 7'b0100100;
      4'd6:    o_seg = 7'b0100000;
      4'd7:    o_seg = 7'b0001111;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0000100;
      default: o_seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/led7_scan_ctrl.sv
// Time-multiplexed NDIG-digit 7-segment scanner with anti-ghost blanking,
// frame-synchronous (tear-free) digit updates and optional leading-zero suppression.
module led7_scan_ctrl
  import led7_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*NDIG-1:0]   value,
  input  logic                load,
  input  logic                lz_en,
  output logic                pending,
  output logic                frame_tick,
  output logic [NDIG-1:0]     an,
  output logic [6:0]          seg
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [4*NDIG-1:0]    r_disp, r_shadow;
  logic                 r_pending, r_tick;
  logic [NDIG-1:0]      r_an;
  logic [6:0]           r_seg;

  logic                 w_slot_end, w_fb, w_blank_win, w_lz, w_unused_mask;
  logic [4*MAX_DIG-1:0] w_disp_ext;
  logic [MAX_DIG-1:0]   w_mask_full;
  bcd_t                 w_dig;
  logic [NDIG-1:0]      w_an_sel, w_an_nxt;
  logic [6:0]           w_dec_seg, w_seg_nxt;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_fb       = w_slot_end && (r_idx == IDX_LAST);

  // Anti-ghost gap at the head of each slot; a zero-length gap never blanks.
  generate
    if (BLANK == 0) begin : g_noblank
      assign w_blank_win = 1'b0;
    end else begin : g_blank
      assign w_blank_win = (r_cnt < CW'(BLANK));
    end
    if (NDIG < MAX_DIG) begin : g_unused
      assign w_unused_mask = ^w_mask_full[MAX_DIG-1:NDIG];
    end else begin : g_full
      assign w_unused_mask = 1'b0;
    end
  endgenerate

  always_comb begin
    w_disp_ext              = '0;
    w_disp_ext[4*NDIG-1:0]  = r_disp;
  end

  assign w_mask_full = lz_mask(w_disp_ext, lz_en);

  // Explicit compare mux so idx codes past NDIG-1 select nothing.
  always_comb begin
    w_dig    = '0;
    w_lz     = 1'b0;
    w_an_sel = '1;
    for (int k = 0; k < NDIG; k++) begin
      if (r_idx == IW'(k)) begin
        w_dig       = r_disp[4*k +: 4];
        w_lz        = w_mask_full[k];
        w_an_sel[k] = 1'b0;
      end
    end
  end

  led7 u_dec (
    .i_bcd (w_dig),
    .o_seg (w_dec_seg)
  );

  assign w_an_nxt  = w_blank_win ? '1 : w_an_sel;
  assign w_seg_nxt = (w_blank_win || w_lz || (w_dig > 4'd9)) ? SEG_BLANK : w_dec_seg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_disp    <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_tick    <= 1'b0;
      r_an      <= '1;
      r_seg     <= SEG_BLANK;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_tick <= w_fb;

      // A load coinciding with the frame boundary bypasses the shadow.
      if (w_fb) begin
        if (load) begin
          r_disp   <= value;
          r_shadow <= value;
        end else if (r_pending) begin
          r_disp   <= r_shadow;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_shadow  <= value;
        r_pending <= 1'b1;
      end

      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign pending    = r_pending;
  assign frame_tick = r_tick;
  assign an         = r_an;
  assign seg        = r_seg;

endmodule

// File: tb/tb_led7_scan_ctrl.sv
// Randomized self-checking bench for led7_scan_ctrl against a frame-position reference model.
module tb_led7_scan_ctrl;

  localparam int N  = 4, D  = 8, B = 2, FR  = N * D;
  localparam int N2 = 3, D2 = 5,        FR2 = N2 * D2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   value = '0;
  logic          load = 1'b0;
  logic          lz_en = 1'b0;
  logic          pending, frame_tick;
  logic [3:0]    an;
  logic [6:0]    seg;

  logic [11:0]   value2 = '0;
  logic          load2 = 1'b0, lz2 = 1'b0;
  logic          pending2, frame_tick2;
  logic [2:0]    an2;
  logic [6:0]    seg2;

  int n_chk = 0, n_fail = 0;

  // reference state: position within the frame plus the digit registers
  int          p = 0, p2 = 0;
  logic [15:0] m_disp = '0, m_shadow = '0;
  bit          m_pend = 0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  bit          e_pend, e_tick;
  logic [2:0]  e_an2;
  logic [6:0]  e_seg2;
  bit          e_tick2;

  always #5 clk = ~clk;

  led7_scan_ctrl #(.NDIG(N), .DIV(D), .BLANK(B)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .lz_en(lz_en),
    .pending(pending), .frame_tick(frame_tick), .an(an), .seg(seg));

  led7_scan_ctrl #(.NDIG(N2), .DIV(D2), .BLANK(0)) dut2 (
    .clk(clk), .reset(reset), .value(value2), .load(load2), .lz_en(lz2),
    .pending(pending2), .frame_tick(frame_tick2), .an(an2), .seg(seg2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  default: return 7'h7F;
    endcase
  endfunction

  // One clock: predict from pre-edge state and inputs, then compare after the edge.
  task automatic cycle();
    int c, k, d, top;
    bit fb;
    if (reset) begin
      e_an = '1; e_seg = 7'h7F; e_tick = 0;
      p = 0; m_disp = '0; m_shadow = '0; m_pend = 0;
      e_an2 = '1; e_seg2 = 7'h7F; e_tick2 = 0; p2 = 0;
    end else begin
      c = p % D; k = p / D; fb = (p == FR - 1);
      e_an = '1; e_seg = 7'h7F;
      if (c >= B) begin
        e_an[k] = 1'b0;
        d = int'(m_disp[4*k +: 4]);
        top = 0;
        for (int j = 0; j < N; j++) if (m_disp[4*j +: 4] != 0) top = j;
        if (!(d > 9 || (lz_en && k > top))) e_seg = seg_ref(d);
      end
      e_tick = fb;
      if (fb) begin
        if (load) begin m_disp = value; m_shadow = value; end
        else if (m_pend) m_disp = m_shadow;
        m_pend = 0;
      end else if (load) begin
        m_shadow = value; m_pend = 1;
      end
      p = (p + 1) % FR;

      e_an2 = '1; e_an2[p2 / D2] = 1'b0;
      e_seg2 = seg_ref(0);
      e_tick2 = (p2 == FR2 - 1);
      p2 = (p2 + 1) % FR2;
    end
    e_pend = m_pend;
    @(posedge clk); #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("pending", 32'(pending), 32'(e_pend));
    check("frame_tick", 32'(frame_tick), 32'(e_tick));
    check("an2", 32'(an2), 32'(e_an2));
    check("seg2", 32'(seg2), 32'(e_seg2));
    check("frame_tick2", 32'(frame_tick2), 32'(e_tick2));
    check("pending2", 32'(pending2), 32'd0);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 2 * FR && p != target; i++) cycle();
    check("run_to_reached", 32'(p), 32'(target));
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (70) cycle();

    // mid-frame load of 1234; slot 0 shows digit 4 after the frame boundary
    run_to(5);
    value = 16'h1234; load = 1'b1; cycle(); load = 1'b0;
    check("pending_after_load", 32'(pending), 32'd1);
    value = 16'($urandom);
    run_to(0);
    run_to(4);
    check("slot0_digit4", 32'(seg), 32'(7'b1001100));
    check("slot0_an", 32'(an), 32'(4'b1110));
    repeat (40) cycle();

    // load on the boundary cycle, then leading-zero suppression
    run_to(FR - 1);
    value = 16'h0005; load = 1'b1; cycle(); load = 1'b0;
    check("fb_load_pending", 32'(pending), 32'd0);
    lz_en = 1'b1;
    run_to(4);
    check("lz_slot0_5", 32'(seg), 32'(7'b0100100));
    run_to(D + 4);
    check("lz_slot1_blank", 32'(seg), 32'h7F);
    check("lz_slot1_an", 32'(an), 32'(4'b1101));
    repeat (40) cycle();

    // non-BCD code is forced dark, not driven as all-lit
    lz_en = 1'b0; value = 16'h00A0; load = 1'b1; cycle(); load = 1'b0;
    run_to(0);
    run_to(D + 4);
    check("code_A_blank", 32'(seg), 32'h7F);
    run_to(2 * D + 4);
    check("zero_digit", 32'(seg), 32'(7'b0000001));

    // reset in slot 2 with a pending load
    run_to(1);
    value = 16'h4321; load = 1'b1; cycle(); load = 1'b0;
    run_to(2 * D + 3);
    check("pend_before_reset", 32'(pending), 32'd1);
    reset = 1'b1; cycle(); reset = 1'b0;
    check("reset_an", 32'(an), 32'hF);
    check("reset_pending", 32'(pending), 32'd0);
    repeat (40) cycle();

    // randomized traffic
    repeat (3000) begin
      reset = ($urandom_range(0, 599) == 0);
      load  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 2) == 0)
        value = {4'($urandom_range(0, 1)) & 4'($urandom), 4'($urandom_range(0, 1)),
                 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
      else
        value = 16'($urandom);
      cycle();
    end
    reset = 1'b0; load = 1'b0;
    repeat (10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
